neopix_tx: RTL and testbench

- Downstream consumer of the SPI receive stage in the SPI-to-NeoPixel bridge.
- Accepts one-cycle byte strobes (data_valid/data_in) and buffers them in a small synchronous FIFO.
- Serialises each byte MSB-first onto a single WS2812-style NRZ line.
- Emits the low reset/latch gap once the stream runs dry.

---
 rtl/neopix_pkg.sv | 25 ++
 rtl/neopix_tx_byte_fifo.sv | 59 +++++
 rtl/neopix_tx.sv | 149 ++++++++++++++
 tb/tb_neopix_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neopix_pkg.sv
// neopix_pkg: definitions shared by the NeoPixel transmitter and its byte FIFO.
//   - state_t      : encoder FSM states (IDLE, BIT, GAP)
//   - *_DEF        : default WS2812 timing in clk cycles at 50 MHz
//   - BYTE_W       : width of one serialised byte
//   - cnt_width()  : bits needed for a counter that runs 0..max_count-1
package neopix_pkg;

  localparam int BYTE_W   = 8;

  localparam int T0H_DEF  = 20;    // 0.4 us high for a 0 bit
  localparam int T1H_DEF  = 40;    // 0.8 us high for a 1 bit
  localparam int TBIT_DEF = 63;    // bit period
  localparam int TRES_DEF = 2500;  // 50 us latch gap

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BIT  = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/neopix_tx_byte_fifo.sv
// byte_fifo: synchronous first-word-fall-through byte FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (clears pointers only)
//   wr_en      : write request; ignored when full
//   wr_data    : byte to write
//   rd_en      : pop request; ignored when empty
//   rd_data    : head of the FIFO, valid whenever empty=0
//   empty/full : status flags
//   level      : bytes stored, 0..2**AW
module byte_fifo
  import neopix_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [BYTE_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       level
);

  localparam int          DEPTH     = 2 ** AW;
  localparam logic [AW:0] FULL_LVL  = {1'b1, {AW{1'b0}}};

  logic [BYTE_W-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       rd_ptr_reg;
  logic              do_wr;
  logic              do_rd;

  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  // A write while full is dropped even if a pop happens in the same cycle.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/neopix_tx.sv
// neopix_tx: buffers bytes from the SPI receive stage and serialises them
// MSB-first onto a WS2812-style NRZ line, ending each frame with a low
// latch gap once the FIFO runs dry.
//   clk, rst_n : clock, asynchronous active-low reset
//   data_in    : byte to transmit
//   data_valid : one-cycle strobe qualifying data_in
//   dout       : registered serial line
//   busy       : high whenever the encoder is not IDLE
//   fifo_level : bytes currently buffered
//   overflow   : one-cycle pulse when a strobe was dropped (FIFO full)
module neopix_tx
  import neopix_pkg::*;
#(
  parameter int T0H  = T0H_DEF,
  parameter int T1H  = T1H_DEF,
  parameter int TBIT = TBIT_DEF,
  parameter int TRES = TRES_DEF,
  parameter int AW   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              data_valid,
  output logic              dout,
  output logic              busy,
  output logic [AW:0]       fifo_level,
  output logic              overflow
);

  localparam int CYC_W  = cnt_width(TBIT);
  localparam int GCNT_W = cnt_width(TRES);

  localparam logic [CYC_W-1:0]  T0H_C     = CYC_W'(T0H);
  localparam logic [CYC_W-1:0]  T1H_C     = CYC_W'(T1H);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TBIT - 1);
  localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(TRES - 1);

  logic              fifo_empty;
  logic              fifo_full;
  logic [BYTE_W-1:0] fifo_rd_data;
  logic              pop;

  state_t            state_reg,   state_next;
  logic [BYTE_W-1:0] sr_reg,      sr_next;
  logic [2:0]        bit_idx_reg, bit_idx_next;
  logic [CYC_W-1:0]  cyc_reg,     cyc_next;
  logic [GCNT_W-1:0] gcnt_reg,    gcnt_next;
  logic              dout_next;

  byte_fifo #(
    .AW(AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (data_valid),
    .wr_data (data_in),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .level   (fifo_level)
  );

  always_comb begin
    state_next   = state_reg;
    sr_next      = sr_reg;
    bit_idx_next = bit_idx_reg;
    cyc_next     = cyc_reg;
    gcnt_next    = gcnt_reg;
    pop          = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          sr_next      = fifo_rd_data;
          bit_idx_next = 3'd7;
          cyc_next     = '0;
          state_next   = BIT;
        end
      end

      BIT: begin
        if (cyc_reg == CYC_LAST) begin
          cyc_next = '0;
          if (bit_idx_reg != 3'd0) begin
            sr_next      = {sr_reg[BYTE_W-2:0], 1'b0};
            bit_idx_next = bit_idx_reg - 3'd1;
          end else if (!fifo_empty) begin
            // Back-to-back bytes: reload without any idle cycle.
            pop          = 1'b1;
            sr_next      = fifo_rd_data;
            bit_idx_next = 3'd7;
          end else begin
            gcnt_next  = '0;
            state_next = GAP;
          end
        end else begin
          cyc_next = cyc_reg + 1'b1;
        end
      end

      GAP: begin
        // A new byte takes priority over latching, even on the final gap cycle.
        if (!fifo_empty) begin
          pop          = 1'b1;
          sr_next      = fifo_rd_data;
          bit_idx_next = 3'd7;
          cyc_next     = '0;
          state_next   = BIT;
        end else if (gcnt_reg == GCNT_LAST) begin
          state_next = IDLE;
        end else begin
          gcnt_next = gcnt_reg + 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase

    // The line level is computed from the next cycle's state so that the
    // registered dout lines up exactly with cyc inside each bit period.
    dout_next = (state_next == BIT) &&
                (cyc_next < (sr_next[BYTE_W-1] ? T1H_C : T0H_C));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      sr_reg      <= '0;
      bit_idx_reg <= '0;
      cyc_reg     <= '0;
      gcnt_reg    <= '0;
      dout        <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      sr_reg      <= sr_next;
      bit_idx_reg <= bit_idx_next;
      cyc_reg     <= cyc_next;
      gcnt_reg    <= gcnt_next;
      dout        <= dout_next;
      busy        <= (state_next != IDLE);
      overflow    <= data_valid && fifo_full;
    end
  end

endmodule

// File: tb/tb_neopix_tx.sv
// Testbench for neopix_tx. Stimulus pushes every accepted byte into exp_q;
// an independent monitor decodes dout pulse widths into bytes and compares
// them against the queue, also checking bit periods and in-frame gaps.
module tb_neopix_tx;

  localparam int AW   = 4;
  localparam int T0H  = 20;
  localparam int T1H  = 40;
  localparam int TBIT = 63;
  localparam int TRES = 2500;
  localparam int BYTE_CYC = 8 * TBIT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        data_valid = 1'b0;
  logic        dout;
  logic        busy;
  logic [AW:0] fifo_level;
  logic        overflow;

  neopix_tx #(
    .T0H (T0H),
    .T1H (T1H),
    .TBIT(TBIT),
    .TRES(TRES),
    .AW  (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .data_valid(data_valid),
    .dout      (dout),
    .busy      (busy),
    .fifo_level(fifo_level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  int gap_events = 0;
  int last_gap   = 0;
  int ovf_pulses = 0;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: all samples taken on the falling clock edge.
  initial begin : monitor
    logic       prev;
    logic [7:0] acc;
    logic [7:0] e;
    int hi, lo, last_hi, nbits;
    bit active;
    prev = 1'b0; acc = 8'h00; hi = 0; lo = 0; last_hi = 0; nbits = 0; active = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0; hi = 0; lo = 0; nbits = 0; active = 1'b0;
      end else begin
        if (overflow) ovf_pulses++;
        if (dout) begin
          if (!prev) begin
            if (active) begin
              if (nbits != 0) begin
                check("bit_period", last_hi + lo, TBIT);
              end else if (lo != TBIT - last_hi) begin
                gap_events++;
                last_gap = lo - (TBIT - last_hi);
                $display("[TB] in-frame gap of %0d cycles", last_gap);
              end
            end
            hi = 0;
          end
          hi++;
        end else begin
          if (prev) begin
            last_hi = hi;
            active  = 1'b1;
            lo      = 0;
            if (hi == T1H) acc = {acc[6:0], 1'b1};
            else begin
              acc = {acc[6:0], 1'b0};
              if (hi != T0H) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL pulse_width: got %0d expected %0d or %0d", hi, T0H, T1H);
              end
            end
            nbits++;
            if (nbits == 8) begin
              nbits = 0;
              if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("[TB] FAIL unexpected_byte: got %02h expected none", acc);
              end else begin
                e = exp_q.pop_front();
                check("byte", int'(acc), int'(e));
                $display("[TB] byte rx %02h exp %02h", acc, e);
              end
            end
          end
          lo++;
          // Once the frame latches, the next pulse starts a fresh frame.
          if (!busy) active = 1'b0;
        end
        prev = dout;
      end
    end
  end

  // Strobe one byte; called at a falling edge, returns one cycle later.
  task automatic strobe(input logic [7:0] b, input bit accept);
    data_in    = b;
    data_valid = 1'b1;
    if (accept) exp_q.push_back(b);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n;
    n = 0;
    while ((busy || fifo_level != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_reached"}, int'(busy || fifo_level != 0), 0);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin : stim
    int g, o, low_cnt, first_low, hi_cnt;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_dout", int'(dout), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_level", int'(fifo_level), 0);
    check("rst_overflow", int'(overflow), 0);

    // Test 1: single 0xA5, latency, latch gap
    strobe(8'hA5, 1'b1);                       // now at cycle n+1
    check("t1_dout_n1", int'(dout), 0);
    @(negedge clk);                            // cycle n+2
    check("t1_dout_n2", int'(dout), 1);
    check("t1_busy", int'(busy), 1);
    repeat (3003) @(negedge clk);              // last GAP cycle, n+506+2499
    check("t1_busy_last_gap", int'(busy), 1);
    check("t1_dout_gap", int'(dout), 0);
    @(negedge clk);
    check("t1_busy_latched", int'(busy), 0);
    check("t1_level", int'(fifo_level), 0);
    check("t1_queue", exp_q.size(), 0);
    $display("[TB] test1 single byte done");

    // Test 2: 0xFF then 0x00, two cycles apart, contiguous bits
    g = gap_events;
    strobe(8'hFF, 1'b1);
    @(negedge clk);
    strobe(8'h00, 1'b1);
    wait_idle(2 * BYTE_CYC + TRES + 100, "t2");
    check("t2_no_gap", gap_events - g, 0);
    $display("[TB] test2 back-to-back bytes done");

    // Test 3: burst of 18 strobes, one overflow
    g = gap_events;
    o = ovf_pulses;
    for (int i = 0; i < 17; i++) strobe(8'(8'h10 + i), 1'b1);
    check("t3_level_full", int'(fifo_level), 16);
    check("t3_no_ovf_yet", int'(overflow), 0);
    strobe(8'h21, 1'b0);
    check("t3_ovf_pulse", int'(overflow), 1);
    @(negedge clk);
    check("t3_ovf_one_cycle", int'(overflow), 0);
    wait_idle(17 * BYTE_CYC + TRES + 200, "t3");
    check("t3_ovf_count", ovf_pulses - o, 1);
    check("t3_no_gap", gap_events - g, 0);
    $display("[TB] test3 burst overflow done");

    // Test 4a: second byte 999 cycles into GAP -> resumes, busy stays high
    g = gap_events;
    low_cnt = 0;
    strobe(8'hC3, 1'b1);                       // at n+1
    for (int k = 0; k < 505 + 999; k++) begin
      @(negedge clk);
      if (!busy) low_cnt++;
    end
    strobe(8'h5A, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (!busy) low_cnt++;
    end
    check("t4a_busy_held", low_cnt, 0);
    wait_idle(BYTE_CYC + TRES + 100, "t4a");
    check("t4a_gap_events", gap_events - g, 1);
    check("t4a_gap_len", last_gap, 999 + 2);
    $display("[TB] test4a resume from GAP done");

    // Test 4b: second byte 2600 cycles into GAP -> latched, restart from IDLE
    g = gap_events;
    first_low = -1;
    strobe(8'h96, 1'b1);                       // at n+1
    for (int k = 1; k <= 505 + 2600; k++) begin
      @(negedge clk);
      if (!busy && first_low < 0) first_low = k + 1;
    end
    check("t4b_busy_fall", first_low, 506 + TRES);
    strobe(8'h69, 1'b1);
    check("t4b_dout_n1", int'(dout), 0);
    @(negedge clk);
    check("t4b_dout_n2", int'(dout), 1);
    wait_idle(BYTE_CYC + TRES + 100, "t4b");
    check("t4b_no_gap", gap_events - g, 0);
    $display("[TB] test4b restart from IDLE done");

    // Test 5: reset during a 1-bit high phase
    strobe(8'h80, 1'b1);                       // at n+1
    repeat (11) @(negedge clk);                // high phase cycle 10
    check("t5_dout_high", int'(dout), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_dout", int'(dout), 0);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_level", int'(fifo_level), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hi_cnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (dout || busy) hi_cnt++;
    end
    check("t5_quiet_after_reset", hi_cnt, 0);
    $display("[TB] test5 mid-frame reset done");

    // Test 6: write coinciding with internal pop at level 5
    o = ovf_pulses;
    strobe(8'h3C, 1'b1);                       // n, popped at n+1
    strobe(8'h11, 1'b1);
    strobe(8'h22, 1'b1);
    strobe(8'h33, 1'b1);
    strobe(8'h44, 1'b1);
    strobe(8'h55, 1'b1);                       // now at n+6
    repeat (499) @(negedge clk);               // cycle n+505, pop edge ahead
    check("t6_level_before", int'(fifo_level), 5);
    strobe(8'h66, 1'b1);
    check("t6_level_after", int'(fifo_level), 5);
    check("t6_no_ovf", int'(overflow), 0);
    wait_idle(7 * BYTE_CYC + TRES + 200, "t6");
    check("t6_ovf_count", ovf_pulses - o, 0);
    $display("[TB] test6 simultaneous push/pop done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
